// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared constants and state encoding for the single-port memory arbiter.
package pipe_mem_arbiter_pkg;
  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_e;
endpackage

// File: rtl/pipe_mem_arbiter_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_mem_arbiter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (en && (count != '1)) count <= count + W'(1);
  end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access,
// and generates the pipeline stall signals.
module pipe_mem_arbiter #(
  parameter int WORD_SIZE   = pipe_mem_arbiter_pkg::WORD_SIZE,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   if_req,
  input  logic [WORD_SIZE-1:0]   if_addr,
  input  logic                   if_cancel,
  output logic [WORD_SIZE-1:0]   if_instr,
  output logic                   if_done,
  input  logic                   d_readM,
  input  logic                   d_writeM,
  input  logic [WORD_SIZE-1:0]   d_addr,
  input  logic [WORD_SIZE-1:0]   d_wdata,
  output logic [WORD_SIZE-1:0]   d_rdata,
  output logic                   d_done,
  output logic                   stall_if,
  output logic                   stall_mem,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [WORD_SIZE-1:0]   mem_rdata,
  input  logic                   mem_ready,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  import pipe_mem_arbiter_pkg::*;

  arb_state_e           state;
  logic [WORD_SIZE-1:0] lat_addr;
  logic [WORD_SIZE-1:0] lat_wdata;
  logic                 lat_write;
  logic                 cancel_flag;
  logic                 d_req;

  assign d_req = d_readM | d_writeM;

  // Stalls are forced low while reset is held so every output reads zero.
  assign stall_mem = reset_n & d_req & ~d_done;
  assign stall_if  = (reset_n & if_req & ~if_done) | stall_mem;

  // Strobes decode from the async-reset state, so they drop the moment reset asserts.
  assign mem_read  = (state == ARB_IF) | ((state == ARB_D) & ~lat_write);
  assign mem_write = (state == ARB_D) & lat_write;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_write   <= 1'b0;
      cancel_flag <= 1'b0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_instr    <= '0;
      d_rdata     <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          // Data wins: the MEM-stage instruction is older than the fetch.
          if (d_req && !d_done) begin
            state     <= ARB_D;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_write <= d_writeM;
          end else if (if_req && !if_done && !if_cancel) begin
            state       <= ARB_IF;
            lat_addr    <= if_addr;
            cancel_flag <= 1'b0;
          end
        end
        ARB_IF: begin
          if (if_cancel) cancel_flag <= 1'b1;
          if (mem_ready) begin
            state <= ARB_IDLE;
            // A redirect landing on the completion edge also makes this fetch stale.
            if (!(cancel_flag || if_cancel)) begin
              if_instr <= mem_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        ARB_D: begin
          if (mem_ready) begin
            state  <= ARB_IDLE;
            d_done <= 1'b1;
            if (!lat_write) d_rdata <= mem_rdata;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  pipe_mem_arbiter_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (stall_if),
    .count   (stall_cycles)
  );
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter; completions are checked by a scoreboard monitor.
module tb_pipe_mem_arbiter;
  localparam int WS = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, if_cancel, d_readM, d_writeM, mem_ready;
  logic [WS-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [WS-1:0] if_instr, d_rdata, mem_addr, mem_wdata;
  logic          if_done, d_done, stall_if, stall_mem, mem_read, mem_write;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit            is_d;
    logic [WS-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  pipe_mem_arbiter #(.WORD_SIZE(WS), .STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_cancel    (if_cancel),
    .if_instr     (if_instr),
    .if_done      (if_done),
    .d_readM      (d_readM),
    .d_writeM     (d_writeM),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic push(input bit is_d, input logic [WS-1:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_done) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_if: unexpected if_done, instr=%h", if_instr);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_d || if_instr !== mon_e.data) begin
          n_err++;
          $display("FAIL sb_if: got if_instr=%h expected is_d=%0d data=%h", if_instr, mon_e.is_d, mon_e.data);
        end
      end
    end
    if (d_done) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_d: unexpected d_done, rdata=%h", d_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (!mon_e.is_d || d_rdata !== mon_e.data) begin
          n_err++;
          $display("FAIL sb_d: got d_rdata=%h expected is_d=%0d data=%h", d_rdata, mon_e.is_d, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    if_req = 1'b1; d_readM = 1'b1; d_writeM = 1'b0; if_cancel = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #2;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_stall_mem", stall_mem, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    if_req = 1'b0; d_readM = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    cyc();

    // Fetch only, memory ready on the first strobe cycle
    cyc(); if_req = 1; if_addr = 16'h0010; mem_rdata = 16'h6012; mem_ready = 1; push(0, 16'h6012); #2;
    chk("t1_c0_stall_if", stall_if, 1);
    chk("t1_c0_mem_read", mem_read, 0);
    cyc(); #2;
    chk("t1_c1_mem_read", mem_read, 1);
    chk("t1_c1_mem_addr", mem_addr, 16'h0010);
    chk("t1_c1_stall_if", stall_if, 1);
    cyc(); #2;
    chk("t1_c2_if_instr", if_instr, 16'h6012);
    chk("t1_c2_stall_if", stall_if, 0);
    chk("t1_c2_mem_read", mem_read, 0);
    chk("t1_c2_stall_cycles", stall_cycles, 2);
    cyc(); if_req = 0; #2;
    chk("t1_c3_no_regrant", mem_read, 0);

    // Simultaneous fetch and load: data first, fetch takes the d_done slot
    cyc(); if_req = 1; if_addr = 16'h0020; d_readM = 1; d_addr = 16'h0080; mem_rdata = 16'hBEEF;
    mem_ready = 1; push(1, 16'hBEEF); #2;
    chk("t2_c0_stall_mem", stall_mem, 1);
    cyc(); #2;
    chk("t2_c1_mem_read", mem_read, 1);
    chk("t2_c1_mem_addr", mem_addr, 16'h0080);
    cyc(); mem_rdata = 16'h5555; push(0, 16'h5555); #2;
    chk("t2_c2_d_rdata", d_rdata, 16'hBEEF);
    chk("t2_c2_stall_mem", stall_mem, 0);
    chk("t2_c2_stall_if", stall_if, 1);
    cyc(); d_readM = 0; #2;
    chk("t2_c3_mem_addr", mem_addr, 16'h0020);
    chk("t2_c3_mem_read", mem_read, 1);
    cyc(); if_req = 0; #2;
    chk("t2_c4_if_instr", if_instr, 16'h5555);
    chk("t2_c4_stall_cycles", stall_cycles, 6);

    // Store (read also asserted -> write wins) with three wait cycles
    cyc(); d_writeM = 1; d_readM = 1; d_addr = 16'h0040; d_wdata = 16'h1234; mem_ready = 0;
    push(1, 16'hBEEF); #2;
    chk("t3_c0_stall_mem", stall_mem, 1);
    for (int c = 1; c <= 4; c++) begin
      cyc(); d_wdata = 16'hDEAD; if (c == 4) mem_ready = 1; #2;
      chk($sformatf("t3_c%0d_mem_write", c), mem_write, 1);
      chk($sformatf("t3_c%0d_mem_read", c), mem_read, 0);
      chk($sformatf("t3_c%0d_mem_wdata", c), mem_wdata, 16'h1234);
      chk($sformatf("t3_c%0d_mem_addr", c), mem_addr, 16'h0040);
      chk($sformatf("t3_c%0d_stall_mem", c), stall_mem, 1);
    end
    cyc(); #2;
    chk("t3_c5_mem_write", mem_write, 0);
    chk("t3_c5_d_rdata", d_rdata, 16'hBEEF);
    chk("t3_c5_stall_mem", stall_mem, 0);
    cyc(); d_writeM = 0; d_readM = 0; #2;
    chk("t3_c6_no_regrant", mem_write, 0);
    chk("t3_c6_stall_cycles", stall_cycles, 11);

    // Cancelled fetch, then a normal fetch
    cyc(); if_req = 1; if_addr = 16'h0030; mem_rdata = 16'hFFFF; mem_ready = 0; #2;
    cyc(); if_cancel = 1; #2;
    chk("t4_c1_mem_addr", mem_addr, 16'h0030);
    chk("t4_c1_mem_read", mem_read, 1);
    cyc(); if_cancel = 0; mem_ready = 1; #2;
    chk("t4_c2_mem_read", mem_read, 1);
    cyc(); if_addr = 16'h0034; mem_rdata = 16'h7777; push(0, 16'h7777); #2;
    chk("t4_c3_if_done", if_done, 0);
    chk("t4_c3_if_instr", if_instr, 16'h5555);
    chk("t4_c3_mem_read", mem_read, 0);
    cyc(); #2;
    chk("t4_c4_mem_addr", mem_addr, 16'h0034);
    cyc(); if_req = 0; #2;
    chk("t4_c5_if_instr", if_instr, 16'h7777);
    chk("t4_c5_stall_cycles", stall_cycles, 16);

    // Reset in the middle of a load
    cyc(); d_readM = 1; d_addr = 16'h0090; mem_rdata = 16'h4242; mem_ready = 0; #2;
    cyc(); #2;
    chk("t5_c1_mem_read", mem_read, 1);
    #1; reset_n = 0; #1;
    chk("t5_rst_mem_read", mem_read, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    chk("t5_rst_stall_mem", stall_mem, 0);
    chk("t5_rst_stall_cycles", stall_cycles, 0);
    chk("t5_rst_if_instr", if_instr, 0);
    chk("t5_rst_d_rdata", d_rdata, 0);
    cyc(); reset_n = 1; mem_ready = 1; push(1, 16'h4242); #2;
    chk("t5_a0_stall_mem", stall_mem, 1);
    cyc(); #2;
    chk("t5_a1_mem_read", mem_read, 1);
    chk("t5_a1_mem_addr", mem_addr, 16'h0090);
    cyc(); d_readM = 0; #2;
    chk("t5_a2_d_rdata", d_rdata, 16'h4242);
    chk("t5_a2_stall_cycles", stall_cycles, 2);

    // Saturation of the stall counter
    cyc(); d_readM = 1; d_addr = 16'h00A0; mem_ready = 0; #2;
    repeat (16'hFFFC) cyc();
    #2;
    chk("t6_pre_sat", stall_cycles, 16'hFFFE);
    repeat (10) cyc();
    #2;
    chk("t6_sat", stall_cycles, 16'hFFFF);
    mem_ready = 1; mem_rdata = 16'h0A0A; push(1, 16'h0A0A);
    cyc(); d_readM = 0; #2;
    chk("t6_d_rdata", d_rdata, 16'h0A0A);
    chk("t6_sat_hold", stall_cycles, 16'hFFFF);
    cyc(); cyc(); #2;
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
